// File: rtl/run_monitor_if.sv
// Bundles the program-counter input and status outputs that connect a CPU run
// monitor to its surroundings.
interface run_monitor_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 32
);
    // pc_val is sampled on every rising clk edge. There is no valid/ready
    // handshake: the producer keeps pc_val stable around each edge, and every
    // status output is a register that updates only on that edge.
    logic [ADDR_W-1:0] pc_val;
    logic              cpu_rst_n;
    logic              running;
    logic              done;
    logic              timeout;
    logic              stalled;
    logic [CNT_W-1:0]  cycle_count;
    logic [1:0]        state_dbg;

    modport master (
        output pc_val,
        input  cpu_rst_n, running, done, timeout, stalled, cycle_count, state_dbg
    );

    modport slave (
        input  pc_val,
        output cpu_rst_n, running, done, timeout, stalled, cycle_count, state_dbg
    );
endinterface

// File: rtl/run_monitor.sv
// CPU run monitor: holds the CPU in reset for a fixed number of cycles, then
// watches the PC for halt, watchdog expiry, or a stalled PC.
module run_monitor #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] HALT_ADDR    = '1,
    parameter int                RESET_CYCLES = 9,
    parameter int                CNT_W        = 32,
    parameter int unsigned       MAX_CYCLES   = 0,
    parameter int unsigned       STALL_LIMIT  = 0
) (
    input  logic          clk,
    input  logic          reset,
    run_monitor_if.slave  mon
);

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_RUN        = 2'd1,
        ST_HALTED     = 2'd2,
        ST_FAULT      = 2'd3
    } state_t;

    localparam int HOLD_W = $clog2(RESET_CYCLES + 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (RESET_CYCLES == 0) ? '0 : HOLD_W'(RESET_CYCLES - 1);

    // Limits are truncated to the counter width so a limit of zero at that
    // width disables the corresponding check.
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] MAX_M1   = MAX_C - CNT_W'(1);
    localparam logic [CNT_W-1:0] STALL_C  = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    state_t            state_q,   state_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic [CNT_W-1:0]  cyc_q,     cyc_d;
    logic [CNT_W-1:0]  stall_q,   stall_d;
    logic [ADDR_W-1:0] prev_q,    prev_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              running_q,   running_d;
    logic              done_q,      done_d;
    logic              timeout_q,   timeout_d;
    logic              stalled_q,   stalled_d;

    logic [CNT_W-1:0]  cyc_inc;
    logic [CNT_W-1:0]  stall_inc;
    logic              hit_halt;
    logic              hit_wdog;
    logic              hit_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RESET_HOLD;
            hold_q      <= '0;
            cyc_q       <= '0;
            stall_q     <= '0;
            prev_q      <= '0;
            cpu_rst_n_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cyc_q       <= cyc_d;
            stall_q     <= stall_d;
            prev_q      <= prev_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            stalled_q   <= stalled_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cyc_d       = cyc_q;
        stall_d     = stall_q;
        prev_d      = prev_q;
        cpu_rst_n_d = cpu_rst_n_q;
        running_d   = running_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        stalled_d   = stalled_q;

        // Both counters saturate instead of wrapping.
        cyc_inc   = (cyc_q == CNT_ONES) ? cyc_q : cyc_q + CNT_W'(1);
        stall_inc = '0;
        if (mon.pc_val == prev_q) begin
            stall_inc = (stall_q == CNT_ONES) ? stall_q : stall_q + CNT_W'(1);
        end

        hit_halt  = (mon.pc_val == HALT_ADDR);
        hit_wdog  = (MAX_C != '0) && (cyc_q == MAX_M1);
        hit_stall = (STALL_C != '0) && (stall_inc == STALL_C);

        case (state_q)
            ST_RESET_HOLD: begin
                cpu_rst_n_d = 1'b0;
                running_d   = 1'b0;
                hold_d      = hold_q + HOLD_W'(1);
                if ((RESET_CYCLES == 0) || (hold_q == HOLD_LAST)) begin
                    state_d     = ST_RUN;
                    cpu_rst_n_d = 1'b1;
                    running_d   = 1'b1;
                    cyc_d       = '0;
                    stall_d     = '0;
                    prev_d      = mon.pc_val;
                end
            end

            ST_RUN: begin
                cyc_d   = cyc_inc;
                stall_d = stall_inc;
                prev_d  = mon.pc_val;
                // Halt wins over watchdog, watchdog wins over stall.
                if (hit_halt) begin
                    state_d     = ST_HALTED;
                    done_d      = 1'b1;
                    cpu_rst_n_d = 1'b0;
                    running_d   = 1'b0;
                end else if (hit_wdog) begin
                    state_d     = ST_FAULT;
                    timeout_d   = 1'b1;
                    cpu_rst_n_d = 1'b0;
                    running_d   = 1'b0;
                end else if (hit_stall) begin
                    state_d     = ST_FAULT;
                    stalled_d   = 1'b1;
                    cpu_rst_n_d = 1'b0;
                    running_d   = 1'b0;
                end
            end

            ST_HALTED, ST_FAULT: begin
                cpu_rst_n_d = 1'b0;
                running_d   = 1'b0;
            end

            default: begin
                state_d = ST_RESET_HOLD;
            end
        endcase
    end

    assign mon.cpu_rst_n   = cpu_rst_n_q;
    assign mon.running     = running_q;
    assign mon.done        = done_q;
    assign mon.timeout     = timeout_q;
    assign mon.stalled     = stalled_q;
    assign mon.cycle_count = cyc_q;
    assign mon.state_dbg   = state_q;

    a_one_flag: assert property (@(posedge clk) disable iff (!reset)
        $onehot0({done_q, timeout_q, stalled_q}));

endmodule

// File: tb/tb_run_monitor.sv
// Directed checks of run_monitor across several parameter sets sharing one
// clock and reset.
module tb_run_monitor;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    run_monitor_if #(.ADDR_W(16), .CNT_W(32)) if0 ();
    run_monitor_if #(.ADDR_W(16), .CNT_W(32)) if1 ();
    run_monitor_if #(.ADDR_W(16), .CNT_W(32)) if2 ();
    run_monitor_if #(.ADDR_W(16), .CNT_W(32)) if3 ();
    run_monitor_if #(.ADDR_W(8),  .CNT_W(4))  if4 ();

    run_monitor dut0 (.clk(clk), .reset(rst_n), .mon(if0));
    run_monitor #(.MAX_CYCLES(50))  dut1 (.clk(clk), .reset(rst_n), .mon(if1));
    run_monitor #(.STALL_LIMIT(4))  dut2 (.clk(clk), .reset(rst_n), .mon(if2));
    run_monitor #(.MAX_CYCLES(10))  dut3 (.clk(clk), .reset(rst_n), .mon(if3));
    run_monitor #(.ADDR_W(8), .CNT_W(4), .RESET_CYCLES(0))
        dut4 (.clk(clk), .reset(rst_n), .mon(if4));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        if0.pc_val = 16'h0000;
        if1.pc_val = 16'h0000;
        if2.pc_val = 16'h0000;
        if3.pc_val = 16'h0000;
        if4.pc_val = 8'h10;

        // Reset values, then the 9-edge hold and counting from 0.
        #2;
        step(3);
        chk("rst_cpu_rst_n", 32'(if0.cpu_rst_n), 32'd0);
        chk("rst_running",   32'(if0.running),   32'd0);
        chk("rst_done",      32'(if0.done),      32'd0);
        chk("rst_cycles",    if0.cycle_count,    32'd0);
        chk("rst_state",     32'(if0.state_dbg), 32'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step(1);
            chk($sformatf("hold_e%0d", e), 32'(if0.cpu_rst_n), 32'd0);
            if0.pc_val = if0.pc_val + 16'd1;
        end
        step(1);
        if0.pc_val = if0.pc_val + 16'd1;
        chk("e9_cpu_rst_n", 32'(if0.cpu_rst_n), 32'd1);
        chk("e9_running",   32'(if0.running),   32'd1);
        chk("e9_cycles",    if0.cycle_count,    32'd0);
        chk("e9_state",     32'(if0.state_dbg), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            if0.pc_val = if0.pc_val + 16'd1;
            chk($sformatf("count_%0d", k), if0.cycle_count, 32'(k));
        end

        // Halt on the 20th RUN edge.
        if0.pc_val = 16'h0100;
        apply_reset();
        step(9);
        chk("halt_entry_running", 32'(if0.running), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            if0.pc_val = (k == 20) ? 16'hFFFF : 16'h0100 + 16'(k);
            step(1);
            if (k == 19) chk("halt_pre_done", 32'(if0.done), 32'd0);
        end
        chk("halt_done",      32'(if0.done),      32'd1);
        chk("halt_cycles",    if0.cycle_count,    32'd20);
        chk("halt_cpu_rst_n", 32'(if0.cpu_rst_n), 32'd0);
        chk("halt_running",   32'(if0.running),   32'd0);
        chk("halt_timeout",   32'(if0.timeout),   32'd0);
        chk("halt_state",     32'(if0.state_dbg), 32'd2);
        if0.pc_val = 16'h0055;
        step(10);
        chk("halt_hold_done",   32'(if0.done),   32'd1);
        chk("halt_hold_cycles", if0.cycle_count, 32'd20);

        // Watchdog at 50 cycles.
        apply_reset();
        step(9);
        for (int k = 1; k <= 50; k++) begin
            if1.pc_val = 16'(k);
            step(1);
            if (k == 49) begin
                chk("wd_pre_timeout", 32'(if1.timeout), 32'd0);
                chk("wd_pre_cycles",  if1.cycle_count,  32'd49);
            end
        end
        chk("wd_timeout", 32'(if1.timeout),   32'd1);
        chk("wd_cycles",  if1.cycle_count,    32'd50);
        chk("wd_done",    32'(if1.done),      32'd0);
        chk("wd_stalled", 32'(if1.stalled),   32'd0);
        chk("wd_running", 32'(if1.running),   32'd0);
        chk("wd_state",   32'(if1.state_dbg), 32'd3);

        // Stall limit 4 with PC stuck from RUN entry.
        if2.pc_val = 16'h0123;
        apply_reset();
        step(9);
        step(3);
        chk("stall_e3", 32'(if2.stalled), 32'd0);
        step(1);
        chk("stall_e4",        32'(if2.stalled), 32'd1);
        chk("stall_e4_cycles", if2.cycle_count,  32'd4);
        chk("stall_e4_done",   32'(if2.done),    32'd0);
        chk("stall_e4_timeout",32'(if2.timeout), 32'd0);

        // A PC change on edge 3 restarts the stall count.
        if2.pc_val = 16'h0123;
        apply_reset();
        step(9);
        step(2);
        if2.pc_val = 16'h0124;
        step(4);
        chk("stall2_e6",        32'(if2.stalled), 32'd0);
        chk("stall2_e6_cycles", if2.cycle_count,  32'd6);
        step(1);
        chk("stall2_e7",        32'(if2.stalled), 32'd1);
        chk("stall2_e7_cycles", if2.cycle_count,  32'd7);

        // Halt and watchdog on the same edge: halt wins.
        apply_reset();
        step(9);
        for (int k = 1; k <= 10; k++) begin
            if3.pc_val = (k == 10) ? 16'hFFFF : 16'(k * 3);
            step(1);
        end
        chk("prio_done",    32'(if3.done),      32'd1);
        chk("prio_timeout", 32'(if3.timeout),   32'd0);
        chk("prio_cycles",  if3.cycle_count,    32'd10);
        chk("prio_state",   32'(if3.state_dbg), 32'd2);

        // Asynchronous reset mid-RUN, then the full hold repeats.
        if0.pc_val = 16'h0200;
        apply_reset();
        step(9);
        for (int k = 1; k <= 3; k++) begin
            if0.pc_val = if0.pc_val + 16'd1;
            step(1);
        end
        chk("abort_pre_cycles", if0.cycle_count, 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_cpu_rst_n", 32'(if0.cpu_rst_n), 32'd0);
        chk("abort_running",   32'(if0.running),   32'd0);
        chk("abort_cycles",    if0.cycle_count,    32'd0);
        chk("abort_state",     32'(if0.state_dbg), 32'd0);
        chk("abort_dut3_done", 32'(if3.done),      32'd0);
        step(1);
        rst_n = 1'b1;
        step(8);
        chk("abort_hold_e8", 32'(if0.cpu_rst_n), 32'd0);
        step(1);
        chk("abort_e9_cpu_rst_n", 32'(if0.cpu_rst_n), 32'd1);
        chk("abort_e9_cycles",    if0.cycle_count,    32'd0);
        step(1);
        chk("abort_e10_cycles",   if0.cycle_count,    32'd1);

        // Zero hold cycles and counter saturation on a 4-bit counter.
        if4.pc_val = 8'h10;
        apply_reset();
        step(1);
        chk("z_cpu_rst_n", 32'(if4.cpu_rst_n), 32'd1);
        chk("z_cycles",    32'(if4.cycle_count), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            if4.pc_val = 8'h10 + 8'(k);
            step(1);
        end
        chk("sat_cycles",  32'(if4.cycle_count), 32'd15);
        chk("sat_running", 32'(if4.running),     32'd1);
        if4.pc_val = 8'hFF;
        step(1);
        chk("sat_halt_done",   32'(if4.done),        32'd1);
        chk("sat_halt_cycles", 32'(if4.cycle_count), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
